circular_dma_burst_ctrl: RTL and testbench

CIRCULAR_DMA_BURST_CTRL -- requirements
Module: circular_dma_burst_ctrl

---
 rtl/circular_dma_pkg.sv | 14 +
 rtl/circular_dma_burst_limit.sv | 48 ++++
 rtl/circular_dma_burst_ctrl.sv | 165 ++++++++++++++++
 tb/tb_circular_dma_burst_ctrl.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/circular_dma_pkg.sv
// Shared types and constants for the circular DMA burst controller.
package circular_dma_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_FLUSH  = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  // Bursts must never straddle a 4 KiB address page.
  localparam int C_PAGE_BYTES = 4096;

endpackage

// File: rtl/circular_dma_burst_limit.sv
// Largest burst (in beats) that may start at cmd_off without exceeding the
// burst cap, the ring end, the next 4 KiB page or the free space in the ring.
module circular_dma_burst_limit
  import circular_dma_pkg::*;
#(
  parameter int C_AXIS_WIDTH = 64,
  parameter int C_ADDR_WIDTH = 32,
  parameter int C_MAX_BURST  = 16
) (
  input  logic [C_ADDR_WIDTH-1:0]            base_i,
  input  logic [C_ADDR_WIDTH-1:0]            size_i,
  input  logic [C_ADDR_WIDTH-1:0]            cmd_off_i,
  input  logic [C_ADDR_WIDTH-1:0]            rd_ptr_i,
  output logic [$clog2(C_MAX_BURST+1)-1:0]   limit_o
);

  localparam int                    BSH       = $clog2(C_AXIS_WIDTH / 8);
  localparam int                    LW        = $clog2(C_MAX_BURST + 1);
  localparam logic [C_ADDR_WIDTH-1:0] ONE_A     = C_ADDR_WIDTH'(1);
  localparam logic [C_ADDR_WIDTH-1:0] PAGE_A    = C_ADDR_WIDTH'(C_PAGE_BYTES);
  localparam logic [C_ADDR_WIDTH-1:0] PAGE_MASK = C_ADDR_WIDTH'(C_PAGE_BYTES - 1);
  localparam logic [C_ADDR_WIDTH-1:0] MAXB_A    = C_ADDR_WIDTH'(C_MAX_BURST);

  logic [C_ADDR_WIDTH-1:0] used;
  logic [C_ADDR_WIDTH-1:0] free_beats;
  logic [C_ADDR_WIDTH-1:0] ring_beats;
  logic [C_ADDR_WIDTH-1:0] page_off;
  logic [C_ADDR_WIDTH-1:0] page_beats;
  logic [C_ADDR_WIDTH-1:0] lim;

  // Minimum of the four bounds; one beat of ring space is always held back
  // so a full ring is never confused with an empty one.
  always_comb begin
    used = cmd_off_i - rd_ptr_i;
    if (cmd_off_i < rd_ptr_i) used = used + size_i;
    free_beats = (size_i - used) >> BSH;
    if (free_beats != '0) free_beats = free_beats - ONE_A;
    ring_beats = (size_i - cmd_off_i) >> BSH;
    page_off   = (base_i + cmd_off_i) & PAGE_MASK;
    page_beats = (PAGE_A - page_off) >> BSH;
    lim = MAXB_A;
    if (ring_beats < lim) lim = ring_beats;
    if (page_beats < lim) lim = page_beats;
    if (free_beats < lim) lim = free_beats;
    limit_o = LW'(lim);
  end

endmodule

// File: rtl/circular_dma_burst_ctrl.sv
// Circular-ring DMA write controller: sizes bursts from FIFO occupancy and
// ring space, keeps one command in flight and tracks the committed pointer.
module circular_dma_burst_ctrl
  import circular_dma_pkg::*;
#(
  parameter int C_AXIS_WIDTH = 64,
  parameter int C_ADDR_WIDTH = 32,
  parameter int C_MAX_BURST  = 16
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              enable,
  input  logic                              stop_req,
  input  logic [C_ADDR_WIDTH-1:0]           mem_base,
  input  logic [C_ADDR_WIDTH-1:0]           mem_size,
  input  logic [C_ADDR_WIDTH-1:0]           mem_rd_ptr,
  output logic                              fifo_enable,
  output logic                              fifo_flush_req,
  input  logic                              fifo_ready,
  input  logic                              fifo_flush_active,
  input  logic                              fifo_flush_ack,
  input  logic [$clog2(C_MAX_BURST+1)-1:0]  fifo_occupancy,
  input  logic                              fifo_beat,
  output logic [C_ADDR_WIDTH-1:0]           cmd_addr,
  output logic [7:0]                        cmd_len,
  output logic                              cmd_valid,
  input  logic                              cmd_ready,
  output logic [C_ADDR_WIDTH-1:0]           wr_ptr,
  output logic                              stopped
);

  localparam int                      LW       = $clog2(C_MAX_BURST + 1);
  localparam int                      BSH      = $clog2(C_AXIS_WIDTH / 8);
  localparam logic [C_ADDR_WIDTH-1:0] ONE_A    = C_ADDR_WIDTH'(1);
  localparam logic [C_ADDR_WIDTH-1:0] BPB_A    = C_ADDR_WIDTH'(C_AXIS_WIDTH / 8);
  localparam logic [LW-1:0]           OCC_FULL = LW'(C_MAX_BURST);

  state_e                  state_q, state_d;
  logic [C_ADDR_WIDTH-1:0] base_q, base_d;
  logic [C_ADDR_WIDTH-1:0] size_q, size_d;
  logic [C_ADDR_WIDTH-1:0] cmd_off_q, cmd_off_d;
  logic [C_ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [8:0]              pending_q, pending_d;
  logic                    cmd_valid_q, cmd_valid_d;
  logic [C_ADDR_WIDTH-1:0] cmd_addr_q, cmd_addr_d;
  logic [7:0]              cmd_len_q, cmd_len_d;

  logic [LW-1:0]           limit;
  logic [LW-1:0]           beats;
  logic [C_ADDR_WIDTH-1:0] next_off;
  logic [C_ADDR_WIDTH-1:0] next_wr;
  logic                    short_ok;
  logic                    occ_ok;
  logic                    issue;

  circular_dma_burst_limit #(
    .C_AXIS_WIDTH (C_AXIS_WIDTH),
    .C_ADDR_WIDTH (C_ADDR_WIDTH),
    .C_MAX_BURST  (C_MAX_BURST)
  ) u_limit (
    .base_i    (base_q),
    .size_i    (size_q),
    .cmd_off_i (cmd_off_q),
    .rd_ptr_i  (mem_rd_ptr),
    .limit_o   (limit)
  );

  // Next-state, command issue, handshake and beat accounting; enable=0 wins.
  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    size_d      = size_q;
    cmd_off_d   = cmd_off_q;
    wr_ptr_d    = wr_ptr_q;
    pending_d   = pending_q;
    cmd_valid_d = cmd_valid_q;
    cmd_addr_d  = cmd_addr_q;
    cmd_len_d   = cmd_len_q;

    next_off = cmd_off_q + ((C_ADDR_WIDTH'(cmd_len_q) + ONE_A) << BSH);
    next_wr  = wr_ptr_q + BPB_A;
    short_ok = (state_q == ST_FLUSH) && fifo_flush_active;
    occ_ok   = short_ok ? (fifo_occupancy != '0) : (fifo_occupancy == OCC_FULL);
    beats    = (short_ok && (fifo_occupancy < limit)) ? fifo_occupancy : limit;
    issue    = ((state_q == ST_ACTIVE) || (state_q == ST_FLUSH)) && fifo_ready &&
               occ_ok && (limit != '0) && (pending_q == '0) && !cmd_valid_q;

    unique case (state_q)
      ST_IDLE: begin
        if (enable) begin
          state_d   = ST_ACTIVE;
          base_d    = mem_base;
          size_d    = mem_size;
          cmd_off_d = '0;
          wr_ptr_d  = '0;
          pending_d = '0;
        end
      end
      ST_ACTIVE: if (stop_req) state_d = ST_FLUSH;
      ST_FLUSH: begin
        if (fifo_flush_ack && (pending_q == '0) && !cmd_valid_q) state_d = ST_DONE;
      end
      default: ;
    endcase

    if (issue) begin
      cmd_valid_d = 1'b1;
      cmd_addr_d  = base_q + cmd_off_q;
      cmd_len_d   = 8'(beats) - 8'd1;
    end

    if (cmd_valid_q && cmd_ready) begin
      cmd_valid_d = 1'b0;
      pending_d   = 9'(cmd_len_q) + 9'd1;
      cmd_off_d   = (next_off >= size_q) ? '0 : next_off;
    end else if (fifo_beat && (pending_q != '0)) begin
      pending_d = pending_q - 9'd1;
      wr_ptr_d  = (next_wr >= size_q) ? '0 : next_wr;
    end

    if (!enable) begin
      state_d     = ST_IDLE;
      cmd_valid_d = 1'b0;
      pending_d   = '0;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Datapath registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      base_q      <= '0;
      size_q      <= '0;
      cmd_off_q   <= '0;
      wr_ptr_q    <= '0;
      pending_q   <= '0;
      cmd_valid_q <= 1'b0;
      cmd_addr_q  <= '0;
      cmd_len_q   <= '0;
    end else begin
      base_q      <= base_d;
      size_q      <= size_d;
      cmd_off_q   <= cmd_off_d;
      wr_ptr_q    <= wr_ptr_d;
      pending_q   <= pending_d;
      cmd_valid_q <= cmd_valid_d;
      cmd_addr_q  <= cmd_addr_d;
      cmd_len_q   <= cmd_len_d;
    end
  end

  assign fifo_enable    = (state_q != ST_IDLE);
  assign fifo_flush_req = (state_q == ST_FLUSH) || (state_q == ST_DONE);
  assign stopped        = (state_q == ST_DONE);
  assign cmd_valid      = cmd_valid_q;
  assign cmd_addr       = cmd_addr_q;
  assign cmd_len        = cmd_len_q;
  assign wr_ptr         = wr_ptr_q;

endmodule

// File: tb/tb_circular_dma_burst_ctrl.sv
// Scoreboard bench for circular_dma_burst_ctrl: a ring-arithmetic model
// predicts each command, a monitor checks every cycle cmd_valid is high.
module tb_circular_dma_burst_ctrl;

  localparam int AW   = 32;
  localparam int MAXB = 16;
  localparam int OW   = $clog2(MAXB + 1);

  typedef struct {
    logic [31:0] addr;
    logic [7:0]  len;
  } cmd_t;

  logic          clk;
  logic          rst_n;
  logic          enable;
  logic          stop_req;
  logic [AW-1:0] mem_base;
  logic [AW-1:0] mem_size;
  logic [AW-1:0] mem_rd_ptr;
  logic          fifo_enable;
  logic          fifo_flush_req;
  logic          fifo_ready;
  logic          fifo_flush_active;
  logic          fifo_flush_ack;
  logic [OW-1:0] fifo_occupancy;
  logic          fifo_beat;
  logic [AW-1:0] cmd_addr;
  logic [7:0]    cmd_len;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [AW-1:0] wr_ptr;
  logic          stopped;

  circular_dma_burst_ctrl #(
    .C_AXIS_WIDTH (64),
    .C_ADDR_WIDTH (AW),
    .C_MAX_BURST  (MAXB)
  ) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .enable            (enable),
    .stop_req          (stop_req),
    .mem_base          (mem_base),
    .mem_size          (mem_size),
    .mem_rd_ptr        (mem_rd_ptr),
    .fifo_enable       (fifo_enable),
    .fifo_flush_req    (fifo_flush_req),
    .fifo_ready        (fifo_ready),
    .fifo_flush_active (fifo_flush_active),
    .fifo_flush_ack    (fifo_flush_ack),
    .fifo_occupancy    (fifo_occupancy),
    .fifo_beat         (fifo_beat),
    .cmd_addr          (cmd_addr),
    .cmd_len           (cmd_len),
    .cmd_valid         (cmd_valid),
    .cmd_ready         (cmd_ready),
    .wr_ptr            (wr_ptr),
    .stopped           (stopped)
  );

  int     n_vec = 0;
  int     n_err = 0;
  cmd_t   exp_q[$];

  longint m_base;
  int     m_size;
  int     m_off;
  int     m_wr;
  bit     m_flush;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: every cycle a command is presented it must match the oldest prediction.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && cmd_valid) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL spurious_cmd: got addr 0x%0h len %0d with nothing expected at %0t",
                   cmd_addr, cmd_len, $time);
        end else begin
          chk("cmd_addr", 64'(cmd_addr), 64'(exp_q[0].addr));
          chk("cmd_len", 64'(cmd_len), 64'(exp_q[0].len));
          if (cmd_ready) void'(exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    #10_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Ring-space rules in plain integer arithmetic.
  function automatic int model_limit(input int off, input int rd);
    int used, free_b, ring_b, page_b, lim;
    used   = ((off - rd) % m_size + m_size) % m_size;
    free_b = (m_size - used) / 8 - 1;
    if (free_b < 0) free_b = 0;
    ring_b = (m_size - off) / 8;
    page_b = (4096 - int'((m_base + longint'(off)) % 4096)) / 8;
    lim = MAXB;
    if (ring_b < lim) lim = ring_b;
    if (page_b < lim) lim = page_b;
    if (free_b < lim) lim = free_b;
    return lim;
  endfunction

  // One transaction: present occupancy/rd_ptr, predict, handshake, deliver beats.
  // cut >= 0 delivers only that many beats and leaves the model untouched.
  task automatic do_cmd(input int occ, input int rd, input bit fa, input bit rdy,
                        input int rdly, input int cut);
    int   lim, beats, n;
    bit   exp_cmd, seen;
    cmd_t e;
    lim = model_limit(m_off, rd);
    if (m_flush && fa) begin
      exp_cmd = rdy && (occ >= 1) && (lim > 0);
      beats   = (occ < lim) ? occ : lim;
    end else begin
      exp_cmd = rdy && (occ == MAXB) && (lim > 0);
      beats   = lim;
    end
    @(posedge clk); #1;
    mem_rd_ptr        = AW'(rd);
    fifo_occupancy    = OW'(occ);
    fifo_flush_active = fa;
    fifo_ready        = rdy;
    cmd_ready         = (rdly == 0);
    if (!exp_cmd) begin
      repeat (6) @(negedge clk);
      chk("no_cmd_valid", 64'(cmd_valid), 64'd0);
      @(posedge clk); #1;
      fifo_occupancy = '0;
      fifo_ready     = 1'b1;
      return;
    end
    e.addr = 32'(m_base + longint'(m_off));
    e.len  = 8'(beats - 1);
    exp_q.push_back(e);
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      seen = cmd_valid;
    end
    if (!seen) begin
      n_vec++;
      n_err++;
      $display("FAIL cmd_timeout: got no cmd_valid, expected addr 0x%0h len %0d", e.addr, e.len);
      exp_q.delete();
      @(posedge clk); #1;
      fifo_occupancy = '0;
      return;
    end
    if (rdly > 0) begin
      repeat (rdly) @(negedge clk);
      @(posedge clk); #1;
      cmd_ready = 1'b1;
    end
    @(posedge clk); #1;
    fifo_occupancy = '0;
    cmd_ready      = 1'b0;
    n = (cut >= 0) ? cut : beats;
    for (int i = 0; i < n; i++) begin
      fifo_beat = 1'b1;
      @(posedge clk); #1;
    end
    fifo_beat = 1'b0;
    if (cut >= 0) return;
    m_off = (m_off + beats * 8) % m_size;
    m_wr  = (m_wr + beats * 8) % m_size;
    chk("wr_ptr", 64'(wr_ptr), 64'(m_wr));
  endtask

  task automatic start_session(input longint base, input int size);
    @(posedge clk); #1;
    enable         = 1'b0;
    stop_req       = 1'b0;
    fifo_occupancy = '0;
    @(posedge clk); #1;
    mem_base = AW'(base);
    mem_size = AW'(size);
    enable   = 1'b1;
    @(posedge clk); #1;
    // Scramble the inputs: the controller must use the latched copies.
    mem_base = 32'hDEAD_0000;
    mem_size = 32'h0000_0080;
    m_base = base; m_size = size; m_off = 0; m_wr = 0; m_flush = 1'b0;
    chk("en_fifo_enable", 64'(fifo_enable), 64'd1);
    chk("en_wr_ptr", 64'(wr_ptr), 64'd0);
    chk("en_stopped", 64'(stopped), 64'd0);
  endtask

  task automatic go_flush();
    @(posedge clk); #1;
    stop_req = 1'b1;
    @(posedge clk); #1;
    stop_req = 1'b0;
    m_flush  = 1'b1;
    chk("flush_req", 64'(fifo_flush_req), 64'd1);
    chk("flush_stopped", 64'(stopped), 64'd0);
  endtask

  task automatic finish_flush();
    @(posedge clk); #1;
    fifo_flush_ack = 1'b1;
    @(posedge clk); #1;
    fifo_flush_ack = 1'b0;
    chk("done_stopped", 64'(stopped), 64'd1);
    chk("done_flush_req", 64'(fifo_flush_req), 64'd1);
    chk("done_fifo_enable", 64'(fifo_enable), 64'd1);
    enable = 1'b0;
    @(posedge clk); #1;
    chk("off_fifo_enable", 64'(fifo_enable), 64'd0);
    chk("off_stopped", 64'(stopped), 64'd0);
    chk("off_flush_req", 64'(fifo_flush_req), 64'd0);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_cmd_valid"}, 64'(cmd_valid), 64'd0);
    chk({tag, "_cmd_addr"}, 64'(cmd_addr), 64'd0);
    chk({tag, "_cmd_len"}, 64'(cmd_len), 64'd0);
    chk({tag, "_wr_ptr"}, 64'(wr_ptr), 64'd0);
    chk({tag, "_fifo_enable"}, 64'(fifo_enable), 64'd0);
    chk({tag, "_flush_req"}, 64'(fifo_flush_req), 64'd0);
    chk({tag, "_stopped"}, 64'(stopped), 64'd0);
  endtask

  initial begin
    int used, rd, occ;
    cmd_t e;
    rst_n = 1'b0; enable = 1'b0; stop_req = 1'b0;
    mem_base = '0; mem_size = '0; mem_rd_ptr = '0;
    fifo_ready = 1'b1; fifo_flush_active = 1'b0; fifo_flush_ack = 1'b0;
    fifo_occupancy = '0; fifo_beat = 1'b0; cmd_ready = 1'b0;
    m_base = 0; m_size = 4096; m_off = 0; m_wr = 0; m_flush = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst_n = 1'b1;

    // Full burst from an empty ring, then stray beats with nothing pending.
    start_session(64'h1000_0000, 'h1000);
    do_cmd(16, 0, 0, 1, 0, -1);
    fifo_beat = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    fifo_beat = 1'b0;
    chk("stray_beat_wr_ptr", 64'(wr_ptr), 64'h80);

    // Walk to offset 0xF80, then a space-limited 8-beat burst lands on 0xFC0.
    for (int i = 0; i < 40 && m_off != 'hF80; i++) do_cmd(16, m_off, 0, 1, 0, -1);
    do_cmd(16, 'hFC8, 0, 1, 0, -1);
    // Ring-end limited burst wraps both pointers to zero.
    do_cmd(16, 'hFC0, 0, 1, 0, -1);
    chk("wrap_wr_ptr", 64'(wr_ptr), 64'd0);
    do_cmd(16, 0, 0, 1, 0, -1);

    // Free-space limit: len 7 first, then nothing at 0x48, then len 6 at 0x80.
    start_session(64'h1000_0000, 'h1000);
    do_cmd(16, 'h48, 0, 1, 0, -1);
    do_cmd(16, 'h48, 0, 1, 0, -1);
    do_cmd(16, 'h80, 0, 1, 0, -1);
    // Not-ready FIFO chain blocks issue.
    do_cmd(16, m_off, 0, 0, 0, -1);

    // Flush with short bursts allowed, then stop.
    go_flush();
    do_cmd(5, m_off, 1, 1, 0, -1);
    finish_flush();

    // Held command under back-pressure, then a mid-burst reset.
    start_session(64'h1000_0000, 'h1000);
    do_cmd(16, 0, 0, 1, 10, -1);
    do_cmd(16, m_off, 0, 1, 0, 3);
    rst_n = 1'b0;
    @(posedge clk); #1;
    check_all_zero("midrst");
    enable = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;

    // enable=0 discards a command still waiting for cmd_ready.
    start_session(64'h1000_0000, 'h1000);
    mem_rd_ptr = '0;
    fifo_occupancy = OW'(MAXB);
    cmd_ready = 1'b0;
    e.addr = 32'h1000_0000;
    e.len  = 8'd15;
    exp_q.push_back(e);
    for (int i = 0; i < 40 && !cmd_valid; i++) @(negedge clk);
    @(posedge clk); #1;
    enable = 1'b0;
    fifo_occupancy = '0;
    @(posedge clk); #1;
    exp_q.delete();
    chk("drop_cmd_valid", 64'(cmd_valid), 64'd0);
    chk("drop_fifo_enable", 64'(fifo_enable), 64'd0);

    // Randomized traffic on a ring that spans a 4 KiB page boundary.
    start_session(64'h2000_3000, 'h2000);
    for (int k = 0; k < 90; k++) begin
      if (k == 60) go_flush();
      used = 8 * int'($urandom_range(0, m_size / 8 - 1));
      if ($urandom_range(0, 3) == 0 && used + 7 < m_size) used += int'($urandom_range(1, 7));
      rd  = ((m_off - used) % m_size + m_size) % m_size;
      occ = ($urandom_range(0, 1) == 1) ? MAXB : int'($urandom_range(0, MAXB));
      do_cmd(occ, rd, 1'($urandom_range(0, 1)), ($urandom_range(0, 7) != 0),
             int'($urandom_range(0, 3)), -1);
    end
    finish_flush();

    repeat (3) @(posedge clk);
    chk("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
